regfile_2r1w_sb: RTL and testbench
==================================

// Module: regfile_2r1w_sb
// PURPOSE
//  Parametrised 2-read/1-write register file with write-first bypass and a per-register
//  pending-write scoreboard. Sits in the decode/writeback path of the MIPS datapath.
//  Decode reads two sources and learns whether either is still awaiting a writeback.
//  Decode also claims its destination; writeback commits data and releases the claim.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W registers
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and claims; 0: register 0 is ordinary
// PORTS
//  clock       in   1          single clock, all state updates on posedge
//  reset       in   1          asynchronous, active-high
//  rd_en       in   1          read request for both source ports this cycle
//  rd_addr_a   in   ADDR_W     source A address
//  rd_addr_b   in   ADDR_W     source B address
//  rd_data_a   out  DATA_W     source A data, registered
//  rd_data_b   out  DATA_W     source B data, registered
//  rd_busy_a   out  1          source A still pending after this cycle's updates, registered
//  rd_busy_b   out  1          source B still pending after this cycle's updates, registered
//  rd_valid    out  1          rd_data_*/rd_busy_* valid (rd_en delayed 1 cycle)
//  wr_en       in   1          writeback commit
//  wr_addr     in   ADDR_W     writeback destination
//  wr_data     in   DATA_W     writeback data
//  claim_en    in   1          mark a destination as pending
//  claim_addr  in   ADDR_W     destination being claimed
//  pend_count  out  ADDR_W+1   number of registers currently pending
// BEHAVIOUR
//  Reset (async, immediate):
//   - All registers clear to 0; all pending bits clear.
//   - rd_data_a/b=0, rd_busy_a/b=0, rd_valid=0, pend_count=0.
//  Write (posedge, wr_en=1):
//   - mem[wr_addr] <= wr_data; pending[wr_addr] <= 0.
//   - Dropped when ZERO_REG=1 and wr_addr==0.
//  Claim (posedge, claim_en=1):
//   - pending[claim_addr] <= 1.
//   - Dropped when ZERO_REG=1 and claim_addr==0.
//   - Claiming an already-pending register leaves it pending; count is unchanged.
//  Write and claim on the same address in the same cycle:
//   - Data is written AND the register stays pending (the new producer wins).
//   - pend_count is unchanged if it was already pending.
//  Read (posedge, rd_en=1), latency 1 cycle:
//   - rd_data_x <= bypass ? wr_data : mem[rd_addr_x].
//   - bypass = wr_en && wr_addr==rd_addr_x && !(ZERO_REG && rd_addr_x==0).
//   - rd_busy_x <= next-state pending[rd_addr_x], i.e. after this edge's write-clear and claim-set.
//   - Register 0 with ZERO_REG=1: data 0, busy 0.
//   - rd_addr_a==rd_addr_b is legal; both ports return identical values.
//  rd_en=0:
//   - rd_data_*/rd_busy_* hold their last values; rd_valid <= 0.
//  pend_count:
//   - Registered; equals the popcount of the pending bits after each edge.
//   - Per-edge delta in {-1,0,+1}.
//   - Never exceeds 2**ADDR_W - ZERO_REG.
//  Address range: all addresses are in range; no wrap or error case exists.
//  Reset asserted mid-operation:
//   - Discards any in-flight read; rd_valid is 0 the cycle after release.
//   - Outstanding claims are lost.
// TESTING
//  1 Reset, then read regs 3/7 -> next cycle rd_valid=1, data 0/0, busy 0/0, pend_count=0.
//  2 Write r5=0xDEADBEEF and read a=5,b=5 in the same cycle
//    -> both return 0xDEADBEEF (bypass); a later read without a write still gives 0xDEADBEEF.
//  3 Write r0=0x1234 and claim r0 (ZERO_REG=1) -> read r0 gives 0, busy 0, pend_count 0.
//  4 Claim r4, then r9 -> pend_count 1 then 2; read r4 -> busy 1.
//    Write r4 -> pend_count 1; read r4 -> busy 0.
//  5 With r6 pending, write r6=0x55 and claim r6 in the same cycle
//    -> r6 data 0x55, busy 1, pend_count unchanged.
//  6 Claim r1..r3, assert reset mid-read -> all outputs 0 immediately; after release, reads busy 0, count 0.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with write-first bypass and a per-register
// pending-write scoreboard for the decode/writeback path.
module regfile_2r1w_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [ADDR_W:0]   pend_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  pending_r;
    logic [DEPTH-1:0]  pending_nxt_s;
    logic [ADDR_W:0]   pend_count_nxt_s;
    logic              wr_ok_s;
    logic              claim_ok_s;
    logic              claim_set_s;
    logic              wr_clear_s;
    logic              zero_a_s;
    logic              zero_b_s;
    logic              bypass_a_s;
    logic              bypass_b_s;

    // Qualify write/claim, compute next pending vector and count delta.
    always_comb begin
        wr_ok_s    = wr_en && !(ZERO_REG && (wr_addr == {ADDR_W{1'b0}}));
        claim_ok_s = claim_en && !(ZERO_REG && (claim_addr == {ADDR_W{1'b0}}));
        zero_a_s   = ZERO_REG && (rd_addr_a == {ADDR_W{1'b0}});
        zero_b_s   = ZERO_REG && (rd_addr_b == {ADDR_W{1'b0}});
        bypass_a_s = wr_ok_s && (wr_addr == rd_addr_a);
        bypass_b_s = wr_ok_s && (wr_addr == rd_addr_b);

        // A claim landing with a write to the same register keeps it pending.
        pending_nxt_s = pending_r;
        for (int i = 0; i < DEPTH; i++) begin
            pending_nxt_s[i] = (claim_ok_s && (claim_addr == ADDR_W'(i))) ? 1'b1 :
                               (wr_ok_s && (wr_addr == ADDR_W'(i)))       ? 1'b0 :
                               pending_r[i];
        end

        claim_set_s = claim_ok_s && !pending_r[claim_addr];
        wr_clear_s  = wr_ok_s && pending_r[wr_addr] &&
                      !(claim_ok_s && (claim_addr == wr_addr));

        case ({claim_set_s, wr_clear_s})
            2'b10:   pend_count_nxt_s = pend_count + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   pend_count_nxt_s = pend_count - {{ADDR_W{1'b0}}, 1'b1};
            default: pend_count_nxt_s = pend_count;
        endcase
    end

    // Register storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard state and pending count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r  <= {DEPTH{1'b0}};
            pend_count <= {(ADDR_W+1){1'b0}};
        end else begin
            pending_r  <= pending_nxt_s;
            pend_count <= pend_count_nxt_s;
        end
    end

    // Registered read ports; data and busy hold when no read is requested.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_a <= {DATA_W{1'b0}};
            rd_data_b <= {DATA_W{1'b0}};
            rd_busy_a <= 1'b0;
            rd_busy_b <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_a <= zero_a_s   ? {DATA_W{1'b0}} :
                             bypass_a_s ? wr_data : mem_r[rd_addr_a];
                rd_data_b <= zero_b_s   ? {DATA_W{1'b0}} :
                             bypass_b_s ? wr_data : mem_r[rd_addr_b];
                rd_busy_a <= !zero_a_s && pending_nxt_s[rd_addr_a];
                rd_busy_b <= !zero_b_s && pending_nxt_s[rd_addr_b];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed, table-driven bench for regfile_2r1w_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
module tb_regfile_2r1w_sb;

    logic        clock;
    logic        reset;
    logic        rd_en;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_busy_a;
    logic        rd_busy_b;
    logic        rd_valid;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [5:0]  pend_count;

    int total_r;
    int bad_r;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        claim_en;
        logic [4:0]  claim_addr;
        logic        rd_en;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ev;
        logic [31:0] eda;
        logic [31:0] edb;
        logic        eba;
        logic        ebb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [13];

    regfile_2r1w_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clock(clock), .reset(reset),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .pend_count(pend_count)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_r++;
        if (act !== exp) begin
            bad_r++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] eda,
                           input logic [31:0] edb, input logic eba, input logic ebb,
                           input logic [5:0] ecnt);
        chk({tag, " rd_valid"},   {31'd0, rd_valid},   {31'd0, ev});
        chk({tag, " rd_data_a"},  rd_data_a,           eda);
        chk({tag, " rd_data_b"},  rd_data_b,           edb);
        chk({tag, " rd_busy_a"},  {31'd0, rd_busy_a},  {31'd0, eba});
        chk({tag, " rd_busy_b"},  {31'd0, rd_busy_b},  {31'd0, ebb});
        chk({tag, " pend_count"}, {26'd0, pend_count}, {26'd0, ecnt});
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ce, input logic [4:0] ca,
                         input logic re, input logic [4:0] ra, input logic [4:0] rb);
        wr_en = we; wr_addr = wa; wr_data = wd;
        claim_en = ce; claim_addr = ca;
        rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Stimulus and checking.
    initial begin
        total_r = 0;
        bad_r   = 0;
        // wr_en wa wd | claim ca | rd ra rb | valid da db ba bb cnt
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd3, 5'd7,
                     1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b1, 5'd5, 5'd5,
                     1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd5, 5'd3,
                     1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  1'b1, 5'd0, 5'd0,
                     1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd0, 5'd0,
                     1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd4, 5'd9,
                     1'b1, 32'h0,        32'h0,        1'b1, 1'b1, 6'd2};
        vecs[6]  = '{1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  1'b1, 5'd4, 5'd9,
                     1'b1, 32'h44,       32'h0,        1'b0, 1'b1, 6'd1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b1, 5'd6, 5'd4,
                     1'b1, 32'h0,        32'h44,       1'b1, 1'b0, 6'd2};
        vecs[8]  = '{1'b1, 5'd6,  32'h55,       1'b1, 5'd6,  1'b1, 5'd6, 5'd6,
                     1'b1, 32'h55,       32'h55,       1'b1, 1'b1, 6'd2};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd6, 5'd9,
                     1'b1, 32'h55,       32'h0,        1'b1, 1'b1, 6'd2};
        vecs[10] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 1'b1, 5'd9, 5'd10,
                     1'b1, 32'h99,       32'h0,        1'b0, 1'b1, 6'd2};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b1, 5'd6, 5'd5,
                     1'b1, 32'h55,       32'hDEADBEEF, 1'b1, 1'b0, 6'd2};
        vecs[12] = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  1'b0, 5'd0, 5'd0,
                     1'b0, 32'h55,       32'hDEADBEEF, 1'b1, 1'b0, 6'd1};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        #2;
        chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                  vecs[i].claim_en, vecs[i].claim_addr,
                  vecs[i].rd_en, vecs[i].ra, vecs[i].rb);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eda, vecs[i].edb,
                    vecs[i].eba, vecs[i].ebb, vecs[i].ecnt);
        end

        // Pending now {10}; claim r1..r3 then hit reset in the middle of a read.
        for (int r = 1; r <= 3; r++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 1'b0, 5'd0, 5'd0);
            step();
            chk($sformatf("claim r%0d count", r), {26'd0, pend_count}, 32'(1 + r));
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd2);
        step();
        chk_all("pre-reset read", 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 6'd4);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd6, 5'd5);
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid-read reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        reset = 1'b0;
        step();
        chk_all("after release", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd6);
        step();
        chk_all("post-reset read", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
